imm_decoder: RTL and testbench
==============================

IMM_DECODER -- requirements
Module: imm_decoder

Interface
REQ-001 SHALL provide port `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL provide port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL provide port `flush`, input, 1 bit: synchronous discard of all buffered entries.
REQ-004 SHALL provide port `in_valid`, input, 1 bit: `instr` carries a valid instruction.
REQ-005 SHALL provide port `in_ready`, output, 1 bit: the block can accept an instruction this cycle.
REQ-006 SHALL provide port `instr`, input, 32 bits: RV32I instruction word.
REQ-007 SHALL provide port `out_valid`, output, 1 bit: the head entry is presented on the outputs.
REQ-008 SHALL provide port `out_ready`, input, 1 bit: the consumer takes the head entry this cycle.
REQ-009 SHALL provide port `imm_type`, output, 3 bits: J=3'b000, U=3'b001, B=3'b010, S=3'b011, I=3'b100, DEFAULT=3'b101.
REQ-010 SHALL provide ports `imm_J`, `imm_U`, `imm_B`, `imm_S`, `imm_I`, output, `REG_LEN` (32) bits each: the decoded immediate for each format.

Function
REQ-011 SHALL decode `imm_type` from `instr[6:0]` as follows:
- 1101111 -> J
- 0110111 and 0010111 -> U
- 1100011 -> B
- 0100011 -> S
- 0010011, 0000011 and 1100111 -> I
- all other opcodes -> DEFAULT
REQ-012 SHALL compute all five immediates for every instruction, regardless of `imm_type`:
- I = sext(instr[31:20])
- S = sext({instr[31:25], instr[11:7]})
- B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
- U = {instr[31:12], 12'h000}
- J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
REQ-013 SHALL buffer decoded entries in a 2-entry in-order FIFO (skid buffer), with occupancy count 0..2.
REQ-014 SHALL accept an instruction on a rising edge where `in_valid` && `in_ready`, and SHALL consume the head entry on a rising edge where `out_valid` && `out_ready`.
REQ-015 SHALL drive `in_ready` = (count != 2) && `rst_n`.
REQ-016 SHALL drive `out_valid` = (count != 0).
REQ-017 SHALL have latency 1: an instruction accepted at edge N, with count 0 before that edge, is presented with `out_valid`=1 in cycle N+1.
REQ-018 SHALL leave count unchanged, while preserving order, when an accept and a consume occur on the same edge with count 1.
REQ-019 SHALL perform only the consume when count is 2 (`in_ready`=0), even if `in_valid`=1.
REQ-020 SHALL hold all outputs stable while `out_valid`=1 and `out_ready`=0.
REQ-021 SHALL give `flush` priority over accept and consume: on an edge with `flush`=1, count becomes 0 and any simultaneously offered instruction is dropped.
REQ-022 SHALL drive `imm_type`=3'b101 and all immediates to 0 when count is 0.
REQ-023 SHALL ignore `out_ready` while `out_valid`=0, with no underflow, and SHALL never increment count beyond 2.
REQ-024 SHALL wrap the FIFO read and write pointers modulo 2.

Reset
REQ-025 SHALL, while `rst_n`=0, immediately and asynchronously force count=0, both pointers=0 and all entry storage=0.
REQ-026 SHALL, while `rst_n`=0, drive `out_valid`=0, `in_ready`=0, `imm_type`=3'b101 and all immediates 0.
REQ-027 SHALL leave `in_ready`=1 from the first cycle after `rst_n` rises, with an empty FIFO.
REQ-028 SHALL abort any transfer in progress when reset is asserted mid-operation, with no partial entry surviving.

Verification
REQ-029 SHALL verify reset: assert `rst_n`=0 mid-stream with count 2 -> same cycle `out_valid`=0, `in_ready`=0, `imm_type`=101, all immediates 0; after release `in_ready`=1.
REQ-030 SHALL verify I-type: `instr`=32'hFFF00093 accepted with `out_ready`=1 -> next cycle `out_valid`=1, `imm_type`=100, `imm_I`=32'hFFFFFFFF.
REQ-031 SHALL verify J and B types:
- 32'h0080006F -> `imm_type`=000, `imm_J`=32'h00000008
- 32'hFE000EE3 -> `imm_type`=010, `imm_B`=32'hFFFFFFFC
REQ-032 SHALL verify backpressure: hold `out_ready`=0 and offer 32'h12345037, 32'h00112023, 32'h00000033.
- `in_ready` drops after the 2nd accept and the 3rd instruction is held.
- Raising `out_ready` then yields, in order: (001, `imm_U`=32'h12345000), (011, `imm_S`=0), (101).
REQ-033 SHALL verify flush: `flush`=1 with count 2 and `in_valid`=1 on the same edge -> next cycle `out_valid`=0, count 0, offered instruction never appears.
REQ-034 SHALL verify steady streaming: `in_valid`=`out_ready`=1 for 8 cycles -> one output per cycle, `in_ready` continuously 1, order preserved.

Source files
------------

// File: rtl/imm_decoder.sv
// ============================================================================
// imm_decoder : RV32I immediate decoder with a 2-entry in-order skid buffer
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imm_decoder #(
  parameter int REG_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         imm_type,
  output logic [REG_LEN-1:0] imm_J,
  output logic [REG_LEN-1:0] imm_U,
  output logic [REG_LEN-1:0] imm_B,
  output logic [REG_LEN-1:0] imm_S,
  output logic [REG_LEN-1:0] imm_I
);

  localparam int          ENTRY_W   = 3 + 5 * REG_LEN;
  localparam logic [2:0]  TYPE_J    = 3'b000;
  localparam logic [2:0]  TYPE_U    = 3'b001;
  localparam logic [2:0]  TYPE_B    = 3'b010;
  localparam logic [2:0]  TYPE_S    = 3'b011;
  localparam logic [2:0]  TYPE_I    = 3'b100;
  localparam logic [2:0]  TYPE_DEF  = 3'b101;
  localparam logic [1:0]  CNT_FULL  = 2'd2;

  logic [2:0]         dec_type;
  logic [REG_LEN-1:0] dec_j, dec_u, dec_b, dec_s, dec_i;
  logic [ENTRY_W-1:0] dec_entry;
  logic [ENTRY_W-1:0] head;

  logic [1:0]         count_q, count_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0] entry_q [2];

  logic               push, pop;

  always_comb begin
    dec_type = TYPE_DEF;
    case (instr[6:0])
      7'b1101111:             dec_type = TYPE_J;
      7'b0110111, 7'b0010111: dec_type = TYPE_U;
      7'b1100011:             dec_type = TYPE_B;
      7'b0100011:             dec_type = TYPE_S;
      7'b0010011, 7'b0000011,
      7'b1100111:             dec_type = TYPE_I;
      default:                dec_type = TYPE_DEF;
    endcase
  end

  // Signed casts sign-extend each raw field out to REG_LEN.
  assign dec_i = REG_LEN'($signed(instr[31:20]));
  assign dec_s = REG_LEN'($signed({instr[31:25], instr[11:7]}));
  assign dec_b = REG_LEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign dec_u = REG_LEN'($signed({instr[31:12], 12'h000}));
  assign dec_j = REG_LEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  assign dec_entry = {dec_type, dec_j, dec_u, dec_b, dec_s, dec_i};

  assign in_ready  = (count_q != CNT_FULL) && rst_n;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) entry_q[i] <= '0;
    end else if (push && !flush) begin
      entry_q[wr_ptr_q] <= dec_entry;
    end
  end

  assign head = entry_q[rd_ptr_q];

  always_comb begin
    imm_type = TYPE_DEF;
    imm_J    = '0;
    imm_U    = '0;
    imm_B    = '0;
    imm_S    = '0;
    imm_I    = '0;
    if (out_valid) begin
      {imm_type, imm_J, imm_U, imm_B, imm_S, imm_I} = head;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_decoder.sv
// ============================================================================
// tb_imm_decoder : directed self-checking bench for imm_decoder
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_imm_decoder;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  imm_type;
  logic [31:0] imm_J, imm_U, imm_B, imm_S, imm_I;

  int checks   = 0;
  int failures = 0;

  imm_decoder #(.REG_LEN(32)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_type  (imm_type),
    .imm_J     (imm_J),
    .imm_U     (imm_U),
    .imm_B     (imm_B),
    .imm_S     (imm_S),
    .imm_I     (imm_I)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = 32'h0;
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
    chk("rst_type",      {29'b0, imm_type},  32'd5);
    chk("rst_imm_I",     imm_I,              32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

    // consuming an empty buffer must not underflow
    out_ready = 1'b1;
    step();
    chk("underflow_out_valid", {31'b0, out_valid}, 32'd0);
    chk("underflow_in_ready",  {31'b0, in_ready},  32'd1);

    // I-type, one-cycle latency
    in_valid = 1'b1;
    instr    = 32'hFFF00093;
    step();
    in_valid = 1'b0;
    chk("I_out_valid", {31'b0, out_valid}, 32'd1);
    chk("I_type",      {29'b0, imm_type},  32'd4);
    chk("I_imm_I",     imm_I,              32'hFFFFFFFF);
    chk("I_imm_S",     imm_S,              32'hFFFFFFE1);
    chk("I_imm_U",     imm_U,              32'hFFF00000);
    step();
    chk("I_drained_valid", {31'b0, out_valid}, 32'd0);
    chk("I_drained_type",  {29'b0, imm_type},  32'd5);
    chk("I_drained_imm_I", imm_I,              32'd0);

    // J-type
    in_valid = 1'b1;
    instr    = 32'h0080006F;
    step();
    chk("J_type",  {29'b0, imm_type}, 32'd0);
    chk("J_imm_J", imm_J,             32'h00000008);
    // B-type, back-to-back with the J consume
    instr = 32'hFE000EE3;
    step();
    in_valid = 1'b0;
    chk("B_type",  {29'b0, imm_type}, 32'd2);
    chk("B_imm_B", imm_B,             32'hFFFFFFFC);
    step();
    chk("B_drained_valid", {31'b0, out_valid}, 32'd0);

    // backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h12345037;
    step();
    chk("bp_ready_after1", {31'b0, in_ready}, 32'd1);
    instr = 32'h00112023;
    step();
    chk("bp_ready_after2", {31'b0, in_ready}, 32'd0);
    chk("bp_head_type",    {29'b0, imm_type}, 32'd1);
    chk("bp_head_U",       imm_U,             32'h12345000);
    instr = 32'h00000033;
    step();
    chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_hold_type",  {29'b0, imm_type}, 32'd1);
    chk("bp_hold_U",     imm_U,             32'h12345000);
    out_ready = 1'b1;
    step();
    chk("bp_out2_type",  {29'b0, imm_type}, 32'd3);
    chk("bp_out2_S",     imm_S,             32'd0);
    chk("bp_out2_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out3_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_out3_type",  {29'b0, imm_type},  32'd5);
    step();
    chk("bp_empty_valid", {31'b0, out_valid}, 32'd0);

    // flush with full buffer and an offered instruction
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h12345037;
    step();
    instr = 32'h00112023;
    step();
    chk("fl_full_ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    instr = 32'h0080006F;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_ready", {31'b0, in_ready},  32'd1);
    chk("fl_type",  {29'b0, imm_type},  32'd5);
    out_ready = 1'b1;
    step();
    chk("fl_nothing_later", {31'b0, out_valid}, 32'd0);

    // flush at count 1 drops an instruction that would otherwise be accepted
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h12345037;
    step();
    flush = 1'b1;
    instr = 32'hFE000EE3;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl1_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("fl1_still_empty", {31'b0, out_valid}, 32'd0);

    // steady streaming: imm_I of entry k is k+1
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      instr = {12'(k + 1), 5'd0, 3'd0, 5'd1, 7'h13};
      step();
      chk($sformatf("st_ready_%0d", k), {31'b0, in_ready},  32'd1);
      chk($sformatf("st_valid_%0d", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("st_imm_%0d", k),   imm_I,              32'(k + 1));
    end
    in_valid = 1'b0;
    step();
    chk("st_drained", {31'b0, out_valid}, 32'd0);

    // asynchronous reset mid-stream with a full buffer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h12345037;
    step();
    instr = 32'h0080006F;
    step();
    in_valid = 1'b0;
    chk("ar_full_ready", {31'b0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_ready", {31'b0, in_ready},  32'd0);
    chk("ar_type",  {29'b0, imm_type},  32'd5);
    chk("ar_imm_U", imm_U,              32'd0);
    chk("ar_imm_J", imm_J,              32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_rel_ready", {31'b0, in_ready},  32'd1);
    chk("ar_rel_valid", {31'b0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
